// File: rtl/enigma_pkg.sv
// Shared types and constants for the three-rotor scrambler sequencer and
// its rotor datapath.
package enigma_pkg;

   typedef logic [4:0] char_t;

   localparam int ALPHA       = 26;
   localparam int NOTCH_R_DEF = 16;
   localparam int NOTCH_M_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STEP   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   // Key positions can arrive as any 5-bit value; fold them into the alphabet.
   function automatic char_t mod_alpha(input char_t v, input int alpha);
      return char_t'(int'(v) % alpha);
   endfunction

endpackage

// File: rtl/enigma_step_decide.sv
// Enigma stepping decision from pre-step positions. The middle rotor also
// steps when it sits on its own notch (double step).
module enigma_step_decide
   import enigma_pkg::*;
(
   input  char_t pos_m_i,
   input  char_t pos_r_i,
   input  char_t notch_m_i,
   input  char_t notch_r_i,
   output logic  step_en_l_o,
   output logic  step_en_m_o,
   output logic  step_en_r_o
);

   logic m_at_notch;
   logic r_at_notch;

   assign m_at_notch  = (pos_m_i == notch_m_i);
   assign r_at_notch  = (pos_r_i == notch_r_i);

   assign step_en_r_o = 1'b1;
   assign step_en_m_o = r_at_notch | m_at_notch;
   assign step_en_l_o = m_at_notch;

endmodule

// File: rtl/enigma_step_ctrl.sv
// Per-character sequencer: key load, stepping pulse, settle wait and result
// handshake for the three-rotor scrambler.
module enigma_step_ctrl
   import enigma_pkg::*;
#(
   parameter int NOTCH_R       = NOTCH_R_DEF,
   parameter int NOTCH_M       = NOTCH_M_DEF,
   parameter int SETTLE_CYCLES = 2,
   parameter int ALPHA         = enigma_pkg::ALPHA
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_valid_in,
   input  logic [4:0]  cfg_pos_l_in,
   input  logic [4:0]  cfg_pos_m_in,
   input  logic [4:0]  cfg_pos_r_in,
   input  logic        char_valid_in,
   input  logic [4:0]  char_in,
   output logic        char_ready_out,
   output logic        res_valid_out,
   output logic [4:0]  res_char_out,
   input  logic        res_ready_in,
   output logic        err_out,
   output logic        rotor_set_out,
   output logic [4:0]  rotor_init_l_out,
   output logic [4:0]  rotor_init_m_out,
   output logic [4:0]  rotor_init_r_out,
   output logic        step_en_l_out,
   output logic        step_en_m_out,
   output logic        step_en_r_out,
   input  logic [4:0]  pos_l_in,
   input  logic [4:0]  pos_m_in,
   input  logic [4:0]  pos_r_in,
   output logic [4:0]  path_char_out,
   input  logic [4:0]  path_res_in,
   output logic        busy_out,
   output logic [15:0] char_count_out
);

   localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   char_t         cfg_l_q, cfg_l_d;
   char_t         cfg_m_q, cfg_m_d;
   char_t         cfg_r_q, cfg_r_d;
   char_t         path_q, path_d;
   char_t         res_q, res_d;
   logic          err_q, err_d;
   logic [15:0]   count_q, count_d;

   logic dec_l, dec_m, dec_r;
   logic in_step;

   // The left position never influences stepping in a three-rotor machine.
   logic unused_pos_l;
   assign unused_pos_l = ^pos_l_in;

   enigma_step_decide u_decide (
      .pos_m_i     (pos_m_in),
      .pos_r_i     (pos_r_in),
      .notch_m_i   (char_t'(NOTCH_M)),
      .notch_r_i   (char_t'(NOTCH_R)),
      .step_en_l_o (dec_l),
      .step_en_m_o (dec_m),
      .step_en_r_o (dec_r)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cfg_l_d = cfg_l_q;
      cfg_m_d = cfg_m_q;
      cfg_r_d = cfg_r_q;
      path_d  = path_q;
      res_d   = res_q;
      err_d   = 1'b0;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid_in) begin
               cfg_l_d = mod_alpha(cfg_pos_l_in, ALPHA);
               cfg_m_d = mod_alpha(cfg_pos_m_in, ALPHA);
               cfg_r_d = mod_alpha(cfg_pos_r_in, ALPHA);
               count_d = '0;
               state_d = ST_LOAD;
            end else if (char_valid_in) begin
               if (int'(char_in) < ALPHA) begin
                  path_d  = char_in;
                  state_d = ST_STEP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: state_d = ST_IDLE;
         ST_STEP: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               res_d   = path_res_in;
               state_d = ST_OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (res_ready_in) begin
               count_d = count_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cfg_l_q <= '0;
         cfg_m_q <= '0;
         cfg_r_q <= '0;
         path_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_l_q <= cfg_l_d;
         cfg_m_q <= cfg_m_d;
         cfg_r_q <= cfg_r_d;
         path_q  <= path_d;
         res_q   <= res_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign in_step          = (state_q == ST_STEP);
   assign step_en_l_out    = in_step & dec_l;
   assign step_en_m_out    = in_step & dec_m;
   assign step_en_r_out    = in_step & dec_r;

   assign char_ready_out   = (state_q == ST_IDLE) & ~cfg_valid_in;
   assign busy_out         = (state_q != ST_IDLE);
   assign res_valid_out    = (state_q == ST_OUT);
   assign res_char_out     = res_q;
   assign err_out          = err_q;
   assign rotor_set_out    = (state_q == ST_LOAD);
   assign rotor_init_l_out = cfg_l_q;
   assign rotor_init_m_out = cfg_m_q;
   assign rotor_init_r_out = cfg_r_q;
   assign path_char_out    = path_q;
   assign char_count_out   = count_q;

endmodule

// File: doc/enigma_step_ctrl.md
Name: enigma_step_ctrl

Overview:
Sequencer for a three-rotor scrambler built from `rotor` instances (right/middle/left) plus an external combinational reflector path. It loads the start key, decides per-character stepping with Enigma double-step rules, and presents each character to the rotor chain. After a settle delay it samples the result and returns it through a valid/ready handshake. It sits between the character I/O front end and the rotor datapath.

Parameters:
NOTCH_R, 16, right-rotor notch position (0..25)
NOTCH_M, 4, middle-rotor notch position (0..25)
SETTLE_CYCLES, 2, cycles (>=1) between the step pulse completing and sampling the path result
ALPHA, 26, alphabet size; legal character codes are 0..ALPHA-1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cfg_valid_in  in  1  key-load request; sampled only in IDLE
cfg_pos_l_in / cfg_pos_m_in / cfg_pos_r_in  in  5 each  start positions
char_valid_in  in  1  input character valid
char_in  in  5  input character code
char_ready_out  out  1  high only in IDLE with cfg_valid_in low
res_valid_out  out  1  result valid
res_char_out  out  5  scrambled character
res_ready_in  in  1  downstream ready
err_out  out  1  one-cycle pulse when an illegal character (>=ALPHA) is accepted
rotor_set_out  out  1  one-cycle set pulse to all three rotors
rotor_init_l/m/r_out  out  5 each  positions driven with rotor_set_out
step_en_l/m/r_out  out  1 each  one-cycle step enables
pos_l/m/r_in  in  5 each  current rotor positions
path_char_out  out  5  character driven into the right rotor forward input
path_res_in  in  5  reflected, backward-path result
busy_out  out  1  high in every state except IDLE
char_count_out  out  16  characters completed since last key load; wraps at 65535 -> 0

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except char_ready_out, which follows the IDLE rule (high if cfg_valid_in is low). char_count_out is 0.
- FSM states: IDLE, LOAD, STEP, SETTLE, OUT.
- IDLE:
  - cfg_valid_in takes priority over char_valid_in; both high goes to LOAD and the character is not accepted.
  - Char handshake completes when char_valid_in and char_ready_out are both high.
  - Legal character: latch char_in into path_char_out and go to STEP.
  - Illegal character: pulse err_out for one cycle, drop the character, stay in IDLE, char_count_out unchanged.
- LOAD (1 cycle):
  - rotor_set_out=1, rotor_init_*_out = latched cfg positions, char_count_out cleared.
  - Cfg positions >=ALPHA are reduced modulo ALPHA.
  - Returns to IDLE.
- STEP (1 cycle): decide from pos_*_in sampled in this cycle (pre-step values).
  - step_en_r_out=1 always.
  - step_en_m_out=1 if pos_r_in==NOTCH_R or pos_m_in==NOTCH_M (double step).
  - step_en_l_out=1 if pos_m_in==NOTCH_M.
  - Enables are asserted only in this cycle; next state is SETTLE.
- SETTLE: a counter runs SETTLE_CYCLES cycles with path_char_out held. On the last cycle, path_res_in is registered into res_char_out, then go to OUT.
- OUT:
  - res_valid_out=1; res_char_out is stable until the handshake.
  - On res_ready_in: char_count_out increments and state returns to IDLE.
  - res_valid_out drops the cycle after the handshake.
- Latency: accept at cycle 0 -> step pulse at cycle 1 -> res_valid_out high at cycle 2+SETTLE_CYCLES. Throughput is one character per 3+SETTLE_CYCLES cycles with res_ready_in held high.
- Reset mid-operation returns to IDLE immediately and discards any in-flight character. Rotor positions are owned by the rotors and are not touched.
- char_valid_in and cfg_valid_in are ignored in all non-IDLE states.

Decomposition:
- Package enigma_pkg: the char_t 5-bit typedef, the ALPHA constant, the FSM state enum, and the default notch constants shared with rotor instances.
- Sub-module: enigma_step_decide, combinational; pre-step positions plus notches in, three step enables out. Reused by a later multi-rotor variant.
- Settle counter and FSM stay inline.

Test Plan:
- Reset with all inputs idle -> every output 0, char_ready_out=1, busy_out=0; reset_n low mid-SETTLE -> IDLE next edge, res_valid_out never rises.
- Key load (L,M,R)=(0,3,16) with cfg_valid_in=1 -> single-cycle rotor_set_out, init outputs 0/3/16, char_count_out=0.
- Char 0 at positions (0,3,16) -> step_en_r=1, step_en_m=1, step_en_l=0. Then char 1 at (0,4,17) -> all three enables=1 (double step). Then char at (1,5,18) -> only step_en_r=1.
- With SETTLE_CYCLES=2, char accepted at edge N -> res_valid_out at edge N+4; res_char_out equals path_res_in sampled at edge N+3.
- res_ready_in held low 5 cycles -> res_valid_out and res_char_out stable, char_ready_out=0; ready high -> char_count_out increments by 1.
- char_in=27 -> err_out one-cycle pulse, no step enables, char_count_out unchanged; cfg_valid_in and char_valid_in both high in IDLE -> LOAD taken, char_ready_out=0 that cycle.
